// File: rtl/mem_model_param.sv
// mem_model_param
//   Parametrised single-port synchronous memory model. It has byte strobes, a
//   pipelined read path with rd_valid, and an init sweep after reset that
//   writes INIT_VAL to every implemented word.
//
//   Optional feature: define MEM_PARITY_EN to store one even-parity bit per
//   byte and flag mismatches on read through par_err. The storage array is
//   `mem`, so a bench can force bits of it to inject errors.
//
// Ports
//   clk       in   clock, all logic on posedge
//   reset     in   synchronous, active-high
//   wr_en     in   write request (taken only while ready)
//   rd_en     in   read request (taken only while ready)
//   addr      in   word address, shared by read and write
//   wdata     in   write data
//   wstrb     in   byte write enables
//   rdata     out  read data, meaningful while rd_valid; holds otherwise
//   rd_valid  out  one pulse per accepted read, RD_LATENCY cycles later
//   ready     out  high once the init sweep is done
//   addr_err  out  pulse for an accepted request with addr >= DEPTH
//   par_err   out  parity mismatch on read (0 without MEM_PARITY_EN)
module mem_model_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 4,
  parameter int RD_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rd_valid,
  output logic                    ready,
  output logic                    addr_err,
  output logic                    par_err
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int S  = RD_LATENCY - 1;   // index of the output stage
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // The sweep pointer is one bit wider than addr, so DEPTH = 2**ADDR_WIDTH
  // still reaches its terminal count.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_W  = (ADDR_WIDTH+1)'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  aerr;
    logic                  perr;
  } rd_beat_t;

  state_t              state, state_nxt;
  logic [ADDR_WIDTH:0] ptr;
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic          in_range, wr_acc, rd_acc, wr_ok, wr_err_q;
  logic [IW-1:0] aidx, pidx;

  assign in_range = {1'b0, addr} < DEPTH_W;
  assign wr_acc   = ready & wr_en;
  assign rd_acc   = ready & rd_en;
  assign wr_ok    = wr_acc & in_range;
  // Word indices are taken only after the range check or from the sweep
  // pointer, so truncating them to the array index width is safe.
  assign aidx     = addr[IW-1:0];
  assign pidx     = ptr[IW-1:0];

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) ptr <= ptr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      ST_INIT: if (ptr == LAST_W) state_nxt = ST_IDLE;
      ST_IDLE: ready = 1'b1;
      default: state_nxt = ST_INIT;
    endcase
  end

  // ---------------- storage ----------------
`ifdef MEM_PARITY_EN
  logic [NB-1:0] par [0:DEPTH-1];
  logic [NB-1:0] init_par;

  always_comb begin
    init_par = '0;
    for (int b = 0; b < NB; b++) init_par[b] = ^INIT_VAL[8*b +: 8];
  end
`endif

  // The memory has no reset. The init sweep provides the defined contents.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_INIT) begin
        mem[pidx] <= INIT_VAL;
`ifdef MEM_PARITY_EN
        par[pidx] <= init_par;
`endif
      end else if (wr_ok) begin
        for (int b = 0; b < NB; b++) begin
          if (wstrb[b]) begin
            mem[aidx][8*b +: 8] <= wdata[8*b +: 8];
`ifdef MEM_PARITY_EN
            par[aidx][b] <= ^wdata[8*b +: 8];
`endif
          end
        end
      end
    end
  end

  // ---------------- read pipeline ----------------
  // The array is sampled at the accepting edge, before the same-edge write
  // lands, which gives read-before-write on a shared address.
  rd_beat_t beat_in;

  always_comb begin
    beat_in      = '0;
    beat_in.aerr = ~in_range;
    if (in_range) begin
      beat_in.data = mem[aidx];
`ifdef MEM_PARITY_EN
      for (int b = 0; b < NB; b++)
        if ((^mem[aidx][8*b +: 8]) != par[aidx][b]) beat_in.perr = 1'b1;
`endif
    end
  end

  logic [S:0] vld_pipe, vld_d;
  rd_beat_t   beat_pipe [0:S];
  rd_beat_t   beat_d    [0:S];

  for (genvar k = 0; k <= S; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign vld_d[k]  = rd_acc;
      assign beat_d[k] = beat_in;
    end else begin : g_body
      assign vld_d[k]  = vld_pipe[k-1];
      assign beat_d[k] = beat_pipe[k-1];
    end
  end

  // The inner stages shift every cycle. The output stage loads only on a
  // valid beat, so rdata holds between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      for (int k = 0; k <= S; k++) beat_pipe[k] <= '0;
    end else begin
      vld_pipe <= vld_d;
      for (int k = 0; k < S; k++) beat_pipe[k] <= beat_d[k];
      if (vld_d[S]) beat_pipe[S] <= beat_d[S];
    end
  end

  // A dropped write reports its error on the cycle after acceptance.
  always_ff @(posedge clk) begin
    if (reset) wr_err_q <= 1'b0;
    else       wr_err_q <= wr_acc & ~in_range;
  end

  assign rdata    = beat_pipe[S].data;
  assign rd_valid = vld_pipe[S];
  assign addr_err = (vld_pipe[S] & beat_pipe[S].aerr) | wr_err_q;
`ifdef MEM_PARITY_EN
  assign par_err  = vld_pipe[S] & beat_pipe[S].perr;
`else
  assign par_err  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_model_param.sv
// Scoreboard bench for mem_model_param (16-bit words, 6 of 8 addresses,
// read latency 2). The driver pushes expected read beats and write-error
// cycles as it drives. A negedge monitor pops them and compares them against
// the DUT outputs.
module tb_mem_model_param;
  localparam int DW = 16, AW = 3, DEPTH = 6, LAT = 2;

  logic          clk = 1'b0, reset = 1'b1, wr_en = 1'b0, rd_en = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [1:0]    wstrb = '0;
  logic [DW-1:0] rdata;
  logic          rd_valid, ready, addr_err, par_err;

  mem_model_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .RD_LATENCY(LAT),
    .INIT_VAL(16'h0000)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .rd_valid(rd_valid),
    .ready(ready), .addr_err(addr_err), .par_err(par_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          ae;
    logic          pe;
    int            due;
  } exp_t;

  exp_t          sb[$];
  int            wq[$];
  logic [DW-1:0] model [0:DEPTH-1];
  int            cyc = 0, m_cnt = 0;
  logic          m_ready, pe_next = 1'b0;
  int            n_vec = 0, n_err = 0;

  // Reference for ready: low for DEPTH cycles after reset is released.
  assign m_ready = (m_cnt == DEPTH);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) m_cnt <= 0;
    else if (m_cnt < DEPTH) m_cnt <= m_cnt + 1;
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One request per cycle, driven on the negedge. The expected result is
  // computed from the model before the write is applied (read-before-write).
  task automatic op(bit we, bit re, logic [AW-1:0] a, logic [DW-1:0] d, logic [1:0] s);
    exp_t e;
    @(negedge clk);
    wr_en = we; rd_en = re; addr = a; wdata = d; wstrb = s;
    if (m_ready) begin
      if (re) begin
        e.d   = (int'(a) < DEPTH) ? model[a] : '0;
        e.ae  = (int'(a) >= DEPTH);
        e.pe  = pe_next;
        e.due = cyc + LAT;
        sb.push_back(e);
      end
      if (we) begin
        if (int'(a) < DEPTH) begin
          for (int b = 0; b < 2; b++) if (s[b]) model[a][8*b +: 8] = d[8*b +: 8];
        end else begin
          wq.push_back(cyc + 1);
        end
      end
    end
  endtask

  task automatic idle(int n);
    repeat (n) op(1'b0, 1'b0, '0, '0, '0);
  endtask

  // Hold reset for n cycles. Expectations due after the reset edge are dropped.
  task automatic do_reset(int n);
    exp_t keep[$];
    int   wk[$];
    @(negedge clk);
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    foreach (sb[i]) if (sb[i].due <= cyc) keep.push_back(sb[i]);
    foreach (wq[i]) if (wq[i] <= cyc) wk.push_back(wq[i]);
    sb = keep; wq = wk;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  // Requests issued during the sweep must be ignored. Bounded wait for ready.
  task automatic init_window();
    for (int i = 0; i < 20 && !m_ready; i++)
      op(1'(i % 2), 1'b1, AW'(i % 8), 16'hFFFF, 2'b11);
    chk("ready_up", 32'(ready), 32'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic ae_e, pe_e;
    ae_e = 1'b0; pe_e = 1'b0;
    if (wq.size() > 0 && wq[0] == cyc) begin
      void'(wq.pop_front());
      ae_e = 1'b1;
    end
    if (rd_valid) begin
      if (sb.size() == 0) chk("spurious_rd_valid", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("rd_latency", 32'(cyc), 32'(e.due));
        chk("rdata", 32'(rdata), 32'(e.d));
        ae_e = ae_e | e.ae;
        pe_e = e.pe;
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      chk("missing_rd_valid", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    chk("addr_err", 32'(addr_err), 32'(ae_e));
    chk("par_err", 32'(par_err), 32'(pe_e));
    chk("ready", 32'(ready), 32'(m_ready));
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    reset = 1'b0;
    init_window();

    // init contents, back-to-back reads
    for (int a = 0; a < DEPTH; a++) op(1'b0, 1'b1, AW'(a), '0, '0);

    // byte strobes, including an all-zero strobe and an upper-byte-only strobe
    op(1'b1, 1'b0, 3'd3, 16'hBEEF, 2'b01);
    op(1'b1, 1'b0, 3'd4, 16'h1234, 2'b11);
    op(1'b1, 1'b0, 3'd5, 16'hFFFF, 2'b00);
    op(1'b1, 1'b0, 3'd0, 16'hABCD, 2'b10);
    for (int a = 0; a < DEPTH; a++) op(1'b0, 1'b1, AW'(a), '0, '0);

    // read-before-write on a shared address
    op(1'b1, 1'b0, 3'd2, 16'h5555, 2'b11);
    op(1'b1, 1'b1, 3'd2, 16'hAAAA, 2'b11);
    op(1'b0, 1'b1, 3'd2, '0, '0);

    // out-of-range writes and reads, and both together
    op(1'b1, 1'b0, 3'd7, 16'hFFFF, 2'b11);
    idle(1);
    op(1'b1, 1'b0, 3'd6, 16'hFFFF, 2'b11);
    op(1'b0, 1'b1, 3'd6, '0, '0);
    op(1'b0, 1'b1, 3'd7, '0, '0);
    op(1'b1, 1'b1, 3'd7, 16'h0F0F, 2'b11);
    op(1'b0, 1'b1, 3'd5, '0, '0);
    idle(LAT + 1);

    // random traffic
    for (int i = 0; i < 80; i++)
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
         16'($urandom), 2'($urandom_range(0, 3)));
    idle(LAT + 1);

`ifdef MEM_PARITY_EN
    op(1'b1, 1'b0, 3'd1, 16'h0001, 2'b11);
    idle(1);
    force dut.mem[1][0] = 1'b0;
    model[1] = 16'h0000;
    pe_next = 1'b1;
    op(1'b0, 1'b1, 3'd1, '0, '0);
    pe_next = 1'b0;
    idle(LAT + 1);
    release dut.mem[1][0];
    op(1'b1, 1'b0, 3'd1, 16'h0001, 2'b11);
    idle(LAT + 1);
`endif

    // Reset with reads in flight. The sweep must then clear every word again.
    for (int a = 0; a < DEPTH; a++) op(1'b1, 1'b0, AW'(a), 16'h7700 + 16'(a), 2'b11);
    op(1'b0, 1'b1, 3'd1, '0, '0);
    op(1'b0, 1'b1, 3'd2, '0, '0);
    op(1'b0, 1'b1, 3'd3, '0, '0);
    do_reset(2);
    init_window();
    for (int a = 0; a < DEPTH; a++) op(1'b0, 1'b1, AW'(a), '0, '0);
    idle(LAT + 2);

    chk("scoreboard_drained", 32'(sb.size() + wq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
